// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, PS/2 command bytes and default timing for the PS/2 host transmitter
package ps2_pkg;
    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_e;
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] ACK_BYTE    = 8'hFA;
    localparam int INHIBIT_CYCLES_DEF = 10000;
    localparam int RTS_CYCLES_DEF     = 200;
    localparam int TIMEOUT_CYCLES_DEF = 2000000;
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command-byte handshake and frame status between a client (master) and ps2_host_tx (slave)
//   tx_valid/tx_data : byte offered by the client
//   tx_ready         : transmitter idle and able to accept a byte
//   tx_busy          : frame in progress from acceptance until tx_done/tx_err
//   tx_done/tx_err   : one-cycle completion / failure pulses
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    modport master (output tx_valid, tx_data, input tx_ready, tx_busy, tx_done, tx_err);
    modport slave (input tx_valid, tx_data, output tx_ready, tx_busy, tx_done, tx_err);
endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: two-flop synchronizers for the PS/2 clock and data pads plus a falling-edge detector on the clock
//   clk, rst : system clock, synchronous active-high reset (flops reset to the idle-high line level)
//   clk_in, data_in : raw pad levels
//   clk_s, data_s   : synchronized levels
//   clk_fall        : one-cycle pulse when the synchronized clock goes 1 -> 0
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_s,
    output logic data_s,
    output logic clk_fall
);
    logic [1:0] clk_ff, data_ff;
    logic clk_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_ff  <= 2'b11;
            data_ff <= 2'b11;
            clk_d   <= 1'b1;
        end else begin
            clk_ff  <= {clk_ff[0], clk_in};
            data_ff <= {data_ff[0], data_in};
            clk_d   <= clk_ff[1];
        end
    end
    assign clk_s    = clk_ff[1];
    assign data_s   = data_ff[1];
    assign clk_fall = clk_d & ~clk_ff[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, request-to-send, 11-bit frame, device ACK check)
//   clk, rst    : system clock, synchronous active-high reset
//   bus         : ps2_host_tx_if.slave -- tx_valid/tx_data/tx_ready handshake, tx_busy/tx_done/tx_err status
//   ps2_clk_in  : raw PS2_CLK pad level;  ps2_data_in : raw PS2_DATA pad level
//   ps2_clk_oe  : 1 pulls PS2_CLK low;    ps2_data_oe : 1 pulls PS2_DATA low (open drain)
// Optional: define PS2_TX_TIMEOUT_EN to add a per-frame watchdog that aborts after TIMEOUT_CYCLES clocks.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int RTS_CYCLES     = RTS_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave bus,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);
    localparam int CNT_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    ps2_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       bit_cnt, bit_n;
    logic [7:0]       data_q, data_n;
    logic             par_q, par_n;
    logic             oe_q, oe_n;
    logic             done, err, timeout;
    logic             clk_s, data_s, clk_fall;

    ps2_sync_edge u_sync (
        .clk      (clk),
        .rst      (rst),
        .clk_in   (ps2_clk_in),
        .data_in  (ps2_data_in),
        .clk_s    (clk_s),
        .data_s   (data_s),
        .clk_fall (clk_fall)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd;
    // Preloaded to 1 while idle so wd equals the number of cycles elapsed since the handshake.
    always_ff @(posedge clk) begin
        if (rst) wd <= '0;
        else wd <= (state == IDLE) ? WD_W'(1) : wd + 1'b1;
    end
    assign timeout = (state != IDLE) && (wd == WD_W'(TIMEOUT_CYCLES));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            data_q  <= data_n;
            par_q   <= par_n;
            oe_q    <= oe_n;
        end
    end

    // Data-line drive is registered, so every bit change lands the cycle after the detected clock edge.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_cnt;
        data_n  = data_q;
        par_n   = par_q;
        oe_n    = oe_q;
        done    = 1'b0;
        err     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.tx_valid) begin
                    state_n = INHIBIT;
                    cnt_n   = '0;
                    bit_n   = '0;
                    data_n  = bus.tx_data;
                    par_n   = odd_parity(bus.tx_data);
                    oe_n    = 1'b0;
                end
            end
            INHIBIT: begin
                cnt_n = cnt + 1'b1;
                if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    state_n = RTS;
                    cnt_n   = '0;
                    oe_n    = 1'b1;
                end
            end
            RTS: begin
                cnt_n = cnt + 1'b1;
                if (cnt == CNT_W'(RTS_CYCLES - 1)) begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                end
            end
            SHIFT: begin
                if (clk_fall) begin
                    bit_n = bit_cnt + 1'b1;
                    oe_n  = (bit_cnt < 4'd8) ? ~data_q[bit_cnt[2:0]] : (bit_cnt == 4'd8) ? ~par_q : 1'b0;
                    if (bit_cnt == 4'd9) state_n = ACK;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    bit_n   = 4'd11;
                    err     = data_s;
                    state_n = data_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (timeout) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            done    = 1'b0;
            err     = 1'b1;
        end
    end

    // Pulses are masked during reset so an aborted frame never reports completion or failure.
    assign bus.tx_ready = (state == IDLE) && !rst;
    assign bus.tx_busy  = state != IDLE;
    assign bus.tx_done  = done && !rst;
    assign bus.tx_err   = err && !rst;
    assign ps2_clk_oe   = (state == INHIBIT) || (state == RTS);
    assign ps2_data_oe  = oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed self-checking bench for ps2_host_tx with an open-drain bus and a PS/2 device model
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;
    localparam int INH = 100;
    localparam int RTC = 20;
    localparam int TMO = 50000;
    localparam int HP  = 20;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk_oe, ps2_data_oe;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic line_clk, line_data;
    int tests = 0, fails = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, ready_after = 0, clk_oe_idle = 0;
    logic pulse_q = 1'b0;

    assign line_clk  = !(ps2_clk_oe || dev_clk_low);
    assign line_data = !(ps2_data_oe || dev_data_low);

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .RTS_CYCLES     (RTC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .ps2_clk_in  (line_clk),
        .ps2_data_in (line_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.tx_done) done_cnt++;
        if (bus.tx_err) err_cnt++;
        if (bus.tx_done && bus.tx_err) both_cnt++;
        if (ps2_clk_oe && !bus.tx_busy) clk_oe_idle++;
        if (pulse_q && bus.tx_ready) ready_after++;
        pulse_q = bus.tx_done || bus.tx_err;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        tick();
        bus.tx_valid = 1'b0;
    endtask

    task automatic host_rts(input string tag);
        int n;
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < 1000) begin
            n++;
            tick();
        end
        check({tag, "_inhibit_len"}, n, INH);
        n = 0;
        while (ps2_clk_oe && ps2_data_oe && n < 1000) begin
            n++;
            tick();
        end
        check({tag, "_rts_len"}, n, RTC);
        check({tag, "_start_bit"}, {30'b0, ps2_clk_oe, ps2_data_oe}, 32'b01);
    endtask

    task automatic dev_edge(input logic pull_data, output logic sampled);
        repeat (HP) tick();
        dev_data_low = pull_data;
        dev_clk_low  = 1'b1;
        repeat (HP) tick();
        sampled      = line_data;
        dev_clk_low  = 1'b0;
    endtask

    task automatic frame(input string tag, input logic [7:0] b, input logic nack, input logic inject,
                         input logic [9:0] exp_bits);
        logic [9:0] bits;
        logic s;
        int d0, e0, r0, n;
        d0 = done_cnt;
        e0 = err_cnt;
        r0 = ready_after;
        n  = 0;
        send(b);
        check({tag, "_busy"}, 32'(bus.tx_busy), 1);
        check({tag, "_ready_low"}, 32'(bus.tx_ready), 0);
        host_rts(tag);
        for (int k = 0; k < 10; k++) begin
            if (inject && k == 4) begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = CMD_RESET;
                tick();
                bus.tx_valid = 1'b0;
                check({tag, "_inject_ready"}, 32'(bus.tx_ready), 0);
            end
            dev_edge(1'b0, s);
            bits[k] = s;
        end
        check({tag, "_bits"}, 32'(bits), 32'(exp_bits));
        dev_edge(!nack, s);
        repeat (4) tick();
        dev_data_low = 1'b0;
        while (bus.tx_busy && n < 200) begin
            n++;
            tick();
        end
        check({tag, "_idle"}, 32'(bus.tx_busy), 0);
        tick();
        check({tag, "_done"}, done_cnt - d0, nack ? 0 : 1);
        check({tag, "_err"}, err_cnt - e0, nack ? 1 : 0);
        check({tag, "_ready_after"}, ready_after - r0, 1);
    endtask

    initial begin
        int d0, e0, n;
        logic s;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) tick();
        check("rst_clk_oe", 32'(ps2_clk_oe), 0);
        check("rst_data_oe", 32'(ps2_data_oe), 0);
        check("rst_busy", 32'(bus.tx_busy), 0);
        check("rst_done", 32'(bus.tx_done), 0);
        check("rst_err", 32'(bus.tx_err), 0);
        rst = 1'b0;
        tick();
        check("rst_ready", 32'(bus.tx_ready), 1);

        frame("ed", CMD_SET_LED, 1'b0, 1'b0, 10'b11_1110_1101);
        frame("b00", 8'h00, 1'b0, 1'b0, 10'b11_0000_0000);
        frame("b01", 8'h01, 1'b0, 1'b0, 10'b10_0000_0001);
        frame("nack", CMD_ENABLE, 1'b1, 1'b0, 10'b10_1111_0100);
        frame("inject", CMD_SET_LED, 1'b0, 1'b1, 10'b11_1110_1101);

        d0 = done_cnt;
        e0 = err_cnt;
        send(CMD_SET_LED);
        host_rts("midrst");
        for (int k = 0; k < 4; k++) dev_edge(1'b0, s);
        repeat (HP) tick();
        dev_clk_low = 1'b1;
        repeat (5) tick();
        check("midrst_edge5_oe", 32'(ps2_data_oe), 1);
        rst = 1'b1;
        tick();
        check("midrst_lines", {30'b0, ps2_clk_oe, ps2_data_oe}, 0);
        check("midrst_busy", 32'(bus.tx_busy), 0);
        rst = 1'b0;
        dev_clk_low = 1'b0;
        tick();
        check("midrst_ready", 32'(bus.tx_ready), 1);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_no_err", err_cnt - e0, 0);

`ifdef PS2_TX_TIMEOUT_EN
        e0 = err_cnt;
        send(CMD_RESET);
        n = 1;
        while (!bus.tx_err && n < TMO + 100) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, TMO);
        tick();
        check("timeout_lines", {30'b0, ps2_clk_oe, ps2_data_oe}, 0);
        check("timeout_ready", 32'(bus.tx_ready), 1);
        check("timeout_err", err_cnt - e0, 1);
`else
        e0 = err_cnt;
        send(CMD_RESET);
        host_rts("stall");
        n = 0;
        repeat (500) tick();
        check("stall_busy", 32'(bus.tx_busy), 1);
        check("stall_no_err", err_cnt - e0 + n, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("stall_rst_ready", 32'(bus.tx_ready), 1);
`endif

        check("done_err_overlap", both_cnt, 0);
        check("clk_oe_outside_frame", clk_oe_idle, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
